// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the broadcast packet and the ROB age helper.
// Ages are measured from the ROB head so that comparisons stay correct across tag wrap.
package wb_arbiter_pkg;

  localparam int ROB_W  = 5;
  localparam int PREG_W = 7;

  typedef struct packed {
    logic              has_rd;
    logic [PREG_W-1:0] preg;
    logic [31:0]       data;
    logic [ROB_W-1:0]  rob;
  } cdb_pkt_t;

  // Distance from the ROB head; smaller means older.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/wb_src_buffer.sv
// Per-source result buffer: DEPTH slots, ready from registered valids, flush and grant clearing.
// Latency: a write at edge k is a selection candidate in the cycle after edge k. Ready drops only when all slots are full.
module wb_src_buffer
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  cdb_pkt_t               in_pkt,
  input  logic [ROB_W-1:0]       rob_head,
  input  logic                   mispredict,
  input  logic [ROB_W-1:0]       mispredict_tag,
  input  logic [DEPTH-1:0]       grant_oh,
  output logic                   ready,
  output logic [DEPTH-1:0]       live,
  output cdb_pkt_t [DEPTH-1:0]   slot_pkt
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] wr_oh;
  logic [ROB_W-1:0] flush_age;
  logic             in_young;
  logic             free_found;

  always_comb begin
    flush_age = rob_age(mispredict_tag, rob_head);
    in_young  = mispredict && (rob_age(in_pkt.rob, rob_head) > flush_age);
    kill      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      kill[j] = mispredict && vld[j] && (rob_age(slot_pkt[j].rob, rob_head) > flush_age);
    end
    // Lowest free slot from registered valids; a slot granted this cycle is not reused until next cycle.
    wr_oh      = '0;
    free_found = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!vld[j] && !free_found) begin
        wr_oh[j]   = 1'b1;
        free_found = 1'b1;
      end
    end
    if (!in_valid || in_young) begin
      wr_oh = '0;
    end
  end

  assign ready = ~&vld;
  assign live  = vld & ~kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld <= (vld & ~kill & ~grant_oh) | wr_oh;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (wr_oh[j]) begin
        slot_pkt[j] <= in_pkt;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Result-bus arbiter: oldest buffered FU result by ROB age is broadcast each cycle from registered cdb_* outputs.
// Latency 2 edges from accept to broadcast; per-source ready drops only when that source's buffer is full.
// Optional WB_ARB_PERF_EN adds saturating stall and grant counters.
module wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int ROB_W   = 5,
  parameter int PREG_W  = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC-1:0]      src_has_rd,
  input  logic [NUM_SRC*PREG_W-1:0] src_preg,
  input  logic [NUM_SRC*32-1:0]   src_data,
  input  logic [NUM_SRC*ROB_W-1:0] src_rob,
  input  logic [ROB_W-1:0]        rob_head,
  input  logic                    mispredict,
  input  logic [ROB_W-1:0]        mispredict_tag,
  output logic                    cdb_valid,
  output logic                    cdb_has_rd,
  output logic [PREG_W-1:0]       cdb_preg,
  output logic [31:0]             cdb_data,
  output logic [ROB_W-1:0]        cdb_rob,
  output logic [1:0]              cdb_src
`ifdef WB_ARB_PERF_EN
  ,
  output logic [NUM_SRC*32-1:0]   perf_stall,
  output logic [31:0]             perf_grants
`endif
);

  import wb_arbiter_pkg::*;

  cdb_pkt_t                 in_pkt   [NUM_SRC];
  logic [DEPTH-1:0]         live     [NUM_SRC];
  logic [DEPTH-1:0]         grant_oh [NUM_SRC];
  cdb_pkt_t [DEPTH-1:0]     slot_pkt [NUM_SRC];

  logic                     found;
  logic [ROB_W-1:0]         best_age;
  logic [ROB_W-1:0]         cand_age;
  logic [1:0]               best_src;
  int                       best_slot;
  cdb_pkt_t                 sel_pkt;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign in_pkt[s] = '{has_rd: src_has_rd[s],
                         preg:   src_preg[s*PREG_W +: PREG_W],
                         data:   src_data[s*32 +: 32],
                         rob:    src_rob[s*ROB_W +: ROB_W]};

    wb_src_buffer #(.DEPTH(DEPTH)) u_buf (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (src_valid[s]),
      .in_pkt         (in_pkt[s]),
      .rob_head       (rob_head),
      .mispredict     (mispredict),
      .mispredict_tag (mispredict_tag),
      .grant_oh       (grant_oh[s]),
      .ready          (src_ready[s]),
      .live           (live[s]),
      .slot_pkt       (slot_pkt[s])
    );
  end

  // Strict '<' keeps the first-scanned candidate on a tie: lowest source, then lowest slot.
  always_comb begin
    found     = 1'b0;
    best_age  = '0;
    cand_age  = '0;
    best_src  = '0;
    best_slot = 0;
    sel_pkt   = '0;
    grant_oh  = '{default: '0};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (live[s][j]) begin
          cand_age = rob_age(slot_pkt[s][j].rob, rob_head);
          if (!found || cand_age < best_age) begin
            found     = 1'b1;
            best_age  = cand_age;
            best_src  = 2'(s);
            best_slot = j;
          end
        end
      end
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < DEPTH; j++) begin
        grant_oh[s][j] = found && (best_src == 2'(s)) && (best_slot == j);
        if (grant_oh[s][j]) begin
          sel_pkt = slot_pkt[s][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid  <= 1'b0;
      cdb_has_rd <= 1'b0;
      cdb_preg   <= '0;
      cdb_data   <= '0;
      cdb_rob    <= '0;
      cdb_src    <= '0;
    end else begin
      cdb_valid <= found;
      if (found) begin
        cdb_has_rd <= sel_pkt.has_rd;
        cdb_preg   <= sel_pkt.preg;
        cdb_data   <= sel_pkt.data;
        cdb_rob    <= sel_pkt.rob;
        cdb_src    <= best_src;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] stall_cnt [NUM_SRC];
  logic [31:0] grant_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '{default: '0};
      grant_cnt <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (src_valid[s] && !src_ready[s] && stall_cnt[s] != '1) begin
          stall_cnt[s] <= stall_cnt[s] + 1'b1;
        end
      end
      if (found && grant_cnt != '1) begin
        grant_cnt <= grant_cnt + 1'b1;
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_perf
    assign perf_stall[s*32 +: 32] = stall_cnt[s];
  end
  assign perf_grants = grant_cnt;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single result broadcast bus (CDB: PRF write port, ROB completion, dispatch wakeup) between the ALU, branch and memory functional units.
- Each FU writes its result into a small private buffer.
- Each cycle, the oldest buffered result (by ROB age relative to the ROB head) is granted and broadcast from a registered output.
- Buffered results younger than a mispredicted branch are discarded.

Parameters:
- NUM_SRC, 3, number of FU requesters (0=ALU, 1=branch, 2=mem).
- DEPTH, 2, buffer slots per requester.
- ROB_W, 5, ROB tag width.
- PREG_W, 7, physical register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source buffer can accept
- src_has_rd  in  NUM_SRC  result writes a register (0 for store/branch without rd)
- src_preg  in  NUM_SRC*PREG_W  destination preg; source i in bits [i*PREG_W +: PREG_W]
- src_data  in  NUM_SRC*32  result data, same packing
- src_rob  in  NUM_SRC*ROB_W  ROB tag, same packing
- rob_head  in  ROB_W  current ROB head tag
- mispredict  in  1  flush request (one-cycle pulse)
- mispredict_tag  in  ROB_W  ROB tag of the mispredicted branch
- cdb_valid  out  1  broadcast valid
- cdb_has_rd  out  1  broadcast writes PRF
- cdb_preg  out  PREG_W  broadcast preg
- cdb_data  out  32  broadcast data
- cdb_rob  out  ROB_W  broadcast ROB tag
- cdb_src  out  2  granted source index

Behaviour:
- Reset (async, active-high):
  - All slot valids cleared.
  - cdb_valid=0, cdb_has_rd=0, cdb_preg=0, cdb_data=0, cdb_rob=0, cdb_src=0.
  - src_ready=1 for every source once reset deasserts.
  - Reset asserted mid-operation drops all buffered results immediately.
- Age:
  - age(t) = (t - rob_head) mod 2^ROB_W, computed at ROB_W bits.
  - Smaller age is older.
- Accept:
  - src_ready[i] = (source i has a free slot), computed from registered slot valids only.
  - src_ready has no combinational path from grant or mispredict.
  - When all DEPTH slots are full, src_ready[i]=0 even in a cycle where one of them is granted.
  - On src_valid[i] && src_ready[i] at edge k, the result is written into the lowest-index free slot.
- Select:
  - Each cycle, the candidates are all valid slots of all sources.
  - The candidate with minimum age is granted.
  - Tie-break (only possible with a duplicate tag, which is an illegal input) is lowest source index, then lowest slot.
  - The granted slot is cleared at the edge.
  - Its fields load into the cdb_* registers, and cdb_valid=1 in the following cycle.
  - If there are no candidates, cdb_valid=0 next cycle; the other cdb_* outputs hold their values.
- Latency: a result accepted at edge k is earliest on the CDB in the cycle after edge k+1, i.e. 2 edges.
- Throughput: 1 broadcast per cycle in total.
- Flush (mispredict=1 in cycle c):
  - At edge c, every slot with age(rob) > age(mispredict_tag) is cleared.
  - An incoming result with a younger tag is not written, but src_ready semantics are unchanged.
  - Flushed slots are excluded from selection in cycle c, so no younger result is broadcast after edge c.
  - The branch's own result (equal tag) is kept.
- Simultaneous events in one edge, all legal:
  - grant, enqueue on the same source, and flush.
  - A slot freed by grant is reusable from the next cycle.
- No starvation: age order guarantees the ROB head result is granted within NUM_SRC*DEPTH cycles.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined:
  - Adds output perf_stall (NUM_SRC*32 bits): per-source saturating counters of cycles with src_valid[i]=1 && src_ready[i]=0.
  - Adds output perf_grants (32 bits): saturating count of broadcasts.
  - Both counters are cleared by reset.
  - Both counters are not cleared by mispredict.
- When not defined: the ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- types_pkg:
  - typedef cdb_pkt_t {has_rd, preg[6:0], data[31:0], rob[4:0]}.
  - Constants ROB_W=5 and PREG_W=7.
  - Function rob_age(tag, head).
- Sub-module wb_src_buffer:
  - One per source.
  - Holds DEPTH slots, produces ready, performs flush clearing and grant clearing.
  - Exports slot valids and packets to the top-level age selector.

Test Plan:
1. Idle after reset -> cdb_valid=0, src_ready=3'b111; single ALU result preg=12, data=0xDEAD_BEEF, rob=3 at edge k -> cdb_valid=1 with those fields in the cycle after edge k+1, cdb_src=0.
2. rob_head=30; ALU rob=1, branch rob=31, mem rob=30, all at the same edge -> grants in order mem, branch, ALU on 3 consecutive cycles (wrap-around age).
3. Mem source fills DEPTH=2 while older ALU results are granted first -> src_ready[2]=0; third mem src_valid is held; ready returns 1 the cycle after one mem slot is granted; no result lost.
4. rob_head=0; buffers hold tags 2, 5, 7; mispredict_tag=5 -> tags 5 and 2 broadcast, tag 7 never appears; a same-edge incoming tag 9 is dropped.
5. Async reset asserted mid-stream with 4 slots valid -> cdb_valid falls immediately; after release, no stale result is broadcast.
6. WB_ARB_PERF_EN defined, mem held full for 10 cycles with src_valid=1 -> perf_stall[mem]=10, perf_grants equals the number of cdb_valid cycles.
